// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot sequencer.
//   boot_state_t : sequencer FSM states
//   boot_err_t   : error codes reported on the error output
//   END_MARKER   : payload word that marks the entry point
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        START,
        RUN,
        FAULT
    } boot_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } boot_err_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into big-endian 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drops any partial word and returns the byte index to 0
//   byte_valid : byte_data is accepted this cycle
//   byte_data  : incoming byte, first byte of a word lands in [31:24]
//   word       : assembled word, meaningful while word_valid is high
//   word_valid : high in the cycle the 4th byte of a word is accepted
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  byte_idx;
    logic [23:0] shift;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= 2'd0;
            shift    <= 24'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;  // wraps 3 -> 0
            shift    <= {shift[15:0], byte_data};
        end
    end

    // The 4th byte is combined directly so the caller can act on the same edge.
    assign word       = {shift, byte_data};
    assign word_valid = byte_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/boot_sequencer.sv
// UART boot sequencer: reads a header word N and N payload words from the
// receiver, writes them to instruction memory, then releases the core.
//   CLK, RST              : clock, synchronous active-high reset
//   rx_data, rx_valid     : byte stream from the UART receiver
//   boot_req              : level request to start a load
//   cpu_halt              : core has halted; return to IDLE
//   imem_we/addr/wdata    : instruction memory write port
//   cpu_reset, cpu_start  : core reset hold and one-cycle release pulse
//   pc_init               : entry word index (word after the last marker)
//   busy                  : loading (HEADER or LOAD)
//   error                 : 0 none, 1 length overflow, 2 byte timeout
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int unsigned MEM_INST_SIZE  = 1024,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              boot_req,
    input  logic              cpu_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              cpu_start,
    output logic [31:0]       pc_init,
    output logic              busy,
    output logic [1:0]        error
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    boot_state_t       state;
    boot_err_t         err;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   n_words;
    logic [CNT_W-1:0]  idle_cnt;
    logic              loading;
    logic              timeout_hit;
    logic [31:0]       word;
    logic              word_valid;

    assign loading     = (state == HEADER) || (state == LOAD);
    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
    assign timeout_hit = !rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Bytes only count while loading; any other state flushes partial words.
    word_assembler u_word_assembler (
        .clk        (CLK),
        .rst        (RST),
        .clear      (!loading),
        .byte_valid (rx_valid && loading),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            err        <= ERR_NONE;
            word_cnt   <= '0;
            n_words    <= '0;
            idle_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            pc_init    <= '0;
        end else begin
            imem_we <= 1'b0;

            if (!loading || rx_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (boot_req) begin
                        state    <= HEADER;
                        err      <= ERR_NONE;
                        pc_init  <= '0;
                        word_cnt <= '0;
                    end
                end
                HEADER: begin
                    if (timeout_hit) begin
                        err   <= ERR_TIMEOUT;
                        state <= FAULT;
                    end else if (word_valid) begin
                        n_words <= word[ADDR_W:0];
                        if (word > 32'(MEM_INST_SIZE)) begin
                            err   <= ERR_OVERFLOW;
                            state <= FAULT;
                        end else if (word == 32'd0) begin
                            state <= START;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // The count reaches N in the cycle the final write is presented.
                    if (word_cnt == n_words) begin
                        state <= START;
                    end else if (timeout_hit) begin
                        err   <= ERR_TIMEOUT;
                        state <= FAULT;
                    end else if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= word;
                        word_cnt   <= word_cnt + 1'b1;
                        if (word == END_MARKER) begin
                            pc_init <= 32'(word_cnt) + 32'd1;
                        end
                    end
                end
                START: state <= RUN;
                RUN: begin
                    if (cpu_halt) state <= IDLE;
                end
                FAULT: begin
                    if (!boot_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from the state register only, so these stay glitch-free.
    assign busy      = loading;
    assign cpu_start = (state == START);
    assign cpu_reset = !((state == START) || (state == RUN));
    assign error     = err;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: stimulus derives expected memory writes,
// start pulses and entry points from the load protocol; a negedge monitor
// checks them as the DUT presents them.
module tb_boot_sequencer;
    localparam int MEM = 1024;
    localparam int AW  = 10;
    localparam int TO  = 100;

    logic          CLK = 1'b0;
    logic          RST;
    logic [7:0]    rx_data;
    logic          rx_valid, boot_req, cpu_halt;
    logic          imem_we, cpu_reset, cpu_start, busy;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata, pc_init;
    logic [1:0]    error;

    boot_sequencer #(
        .MEM_INST_SIZE  (MEM),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .boot_req   (boot_req),
        .cpu_halt   (cpu_halt),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_start  (cpu_start),
        .pc_init    (pc_init),
        .busy       (busy),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { int pc; int cyc; } st_t;

    wr_t         wq[$];
    st_t         sq[$];
    wr_t         mw;
    st_t         ms;
    logic [31:0] prog[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and start pulse must match the next expected entry.
    always @(negedge CLK) begin
        if (!RST && imem_we) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                mw = wq.pop_front();
                chk("wr_addr", 32'(imem_addr), mw.addr);
                chk("wr_data", imem_wdata, mw.data);
                chk("wr_cycle", cyc, mw.cyc);
            end
        end
        if (!RST && cpu_start) begin
            if (sq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_start: got cpu_start=1, required 0 (cycle %0d)", cyc);
            end else begin
                ms = sq.pop_front();
                chk("start_pc_init", pc_init, ms.pc);
                chk("start_cycle", cyc, ms.cyc);
                chk("start_cpu_reset", 32'(cpu_reset), 0);
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends w MSB first; c returns the cycle in which the last byte was sampled.
    task automatic send_word(input logic [31:0] w, input int gap, output int c);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
        c = cyc;
    endtask

    // junk: drive a byte alongside the request, which must be ignored.
    task automatic start_load(input bit junk, input bit hold);
        boot_req = 1'b1;
        if (junk) begin
            rx_valid = 1'b1;
            rx_data  = 8'hAB;
        end
        tick();
        rx_valid = 1'b0;
        boot_req = hold;
        chk("load_busy", 32'(busy), 1);
        chk("load_error_cleared", 32'(error), 0);
    endtask

    task automatic wait_run;
        int n = 0;
        while (sq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("start_pending", sq.size(), 0);
        sq.delete();
        tick();
        chk("run_cpu_reset", 32'(cpu_reset), 0);
        chk("run_busy", 32'(busy), 0);
    endtask

    task automatic halt;
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("halt_cpu_reset", 32'(cpu_reset), 1);
        chk("halt_busy", 32'(busy), 0);
    endtask

    // Reference: payload i goes to address i; entry point follows the last marker.
    task automatic do_load(input bit junk, input int gap);
        int c;
        int pc;
        start_load(junk, 1'b0);
        send_word(32'(prog.size()), gap, c);
        pc = 0;
        if (prog.size() == 0) begin
            sq.push_back('{pc: 0, cyc: c});
        end else begin
            foreach (prog[i]) begin
                send_word(prog[i], gap, c);
                wq.push_back('{addr: i, data: prog[i], cyc: c});
                if (prog[i] == 32'hFFFF_FFFF) pc = i + 1;
            end
            sq.push_back('{pc: pc, cyc: c + 1});
        end
        wait_run();
        chk("pc_init", pc_init, pc);
    endtask

    task automatic chk_reset_values;
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_cpu_start", 32'(cpu_start), 0);
        chk("rst_pc_init", pc_init, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
    endtask

    initial begin
        int c;
        logic [31:0] w;
        RST      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        boot_req = 1'b0;
        cpu_halt = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        chk_reset_values();

        // Basic load with a byte alongside the request, then reload with only a marker.
        prog = '{32'h1122_3344, 32'hFFFF_FFFF, 32'hAABB_CCDD};
        do_load(1'b1, 0);
        halt();
        prog = '{32'hFFFF_FFFF};
        do_load(1'b0, 0);
        halt();

        // Long gaps below the timeout.
        prog = '{32'h1234_5678};
        do_load(1'b1, 50);
        chk("gap_error", 32'(error), 0);
        halt();

        // Overflow: request held high keeps FAULT; bytes there are ignored.
        start_load(1'b0, 1'b1);
        send_word(32'd1025, 0, c);
        repeat (3) tick();
        chk("ovf_error", 32'(error), 1);
        chk("ovf_busy", 32'(busy), 0);
        chk("ovf_cpu_reset", 32'(cpu_reset), 1);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 1);
        repeat (3) tick();
        chk("ovf_hold_error", 32'(error), 1);
        boot_req = 1'b0;
        repeat (2) tick();
        chk("ovf_sticky_error", 32'(error), 1);

        // Timeout with a partial second word.
        start_load(1'b0, 1'b0);
        send_word(32'd2, 0, c);
        send_word(32'hCAFE_F00D, 0, c);
        wq.push_back('{addr: 0, data: 32'hCAFE_F00D, cyc: c});
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        repeat (TO - 10) tick();
        chk("to_early_error", 32'(error), 0);
        chk("to_early_busy", 32'(busy), 1);
        repeat (20) tick();
        chk("to_error", 32'(error), 2);
        chk("to_busy", 32'(busy), 0);
        chk("to_cpu_reset", 32'(cpu_reset), 1);

        // Mid-load reset after one word and one extra byte.
        start_load(1'b0, 1'b0);
        send_word(32'd4, 0, c);
        send_word(32'h0BAD_BEEF, 1, c);
        wq.push_back('{addr: 0, data: 32'h0BAD_BEEF, cyc: c});
        send_byte(8'h77, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset_values();
        repeat (5) tick();
        chk("rst_still_idle", 32'(busy), 0);

        // Empty program.
        prog.delete();
        do_load(1'b0, 0);
        halt();

        // Random programs with random gaps and occasional markers.
        for (int r = 0; r < 6; r++) begin
            prog.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                prog.push_back(w);
            end
            do_load(1'b0, -1);
            halt();
        end

        repeat (3) tick();
        chk("writes_outstanding", wq.size(), 0);
        chk("starts_outstanding", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Controls the boot of the core over UART.
- Takes the byte stream from the UART receiver and assembles big-endian instruction words. Writes them into instruction memory through a single write port.
- Finds the entry point, holds the CPU in reset while loading, then releases it. Returns to idle when the CPU halts so another program can be loaded.
- Sits between the receiver, the instruction memory and the core's reset/PC-init inputs.

Parameters:
MEM_INST_SIZE, 1024, instruction memory depth in words
ADDR_W, 10, address width; must equal clog2(MEM_INST_SIZE)
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes during a load before aborting

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
rx_data  input  8  received byte; valid only while rx_valid is high
rx_valid  input  1  one-cycle strobe per received byte
boot_req  input  1  level; a load may start while high
cpu_halt  input  1  core reports halt (level)
imem_we  output  1  instruction memory write enable, one-cycle pulse
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  write data
cpu_reset  output  1  holds the core in reset
cpu_start  output  1  one-cycle pulse when the core is released
pc_init  output  32  entry word index for the core
busy  output  1  high in HEADER and LOAD states
error  output  2  0 none, 1 length overflow, 2 byte timeout; sticky until the next load starts

Behaviour:
- Reset values: state IDLE; cpu_reset=1; imem_we=0; cpu_start=0; pc_init=0; busy=0; error=0; imem_addr=0; imem_wdata=0; byte index=0; word count=0; timeout counter=0.
- Word assembly: the first byte of a word goes to [31:24], then [23:16], then [15:8], then [7:0].
- Byte index runs 0..3 and wraps to 0 after the 4th byte.
- Protocol: one header word N (payload length in words), then N payload words.
- IDLE: cpu_reset=1. If boot_req=1, go to HEADER: clear error, pc_init, word count and byte index.
- HEADER:
  - Assemble the header word.
  - On the 4th byte: if N > MEM_INST_SIZE, set error=1 and go to FAULT.
  - Else if N == 0, go to START.
  - Else go to LOAD.
- LOAD:
  - On the 4th byte of each word, in the next cycle: imem_we=1, imem_addr=word count, imem_wdata=assembled word. Word count then increments.
  - If the completed word == 32'hFFFFFFFF: pc_init = word count + 1. The marker is written to memory like any other word. The last marker in the stream wins.
  - After the N-th word is written, go to START.
- START: one cycle; cpu_reset=0, cpu_start=1. Then go to RUN.
- RUN: cpu_reset=0. If cpu_halt=1, go to IDLE with cpu_reset=1 in the same transition. rx_valid is ignored.
- FAULT: cpu_reset=1; rx_valid ignored. If boot_req=0, go to IDLE.
- Timeout:
  - In HEADER/LOAD, a counter increments on every cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES: error=2, go to FAULT. A partial word is discarded; memory already written is not cleared.
  - The counter is inactive in other states.
- rx_valid in IDLE, START, RUN or FAULT is ignored and never changes the byte index.
- An rx_valid in the same cycle as the IDLE→HEADER transition is ignored. Only the first byte after entering HEADER counts.
- boot_req falling during HEADER/LOAD does not abort the load.
- RST asserted mid-load: everything returns to reset values next cycle. No partial write completes.
- Latency: imem_we occurs exactly 1 cycle after the rx_valid of the word's 4th byte. cpu_start occurs 1 cycle after the final write, or 1 cycle after the header if N=0.
- Widths: word count is ADDR_W+1 bits so it can hold MEM_INST_SIZE. pc_init is zero-extended to 32 bits and may equal N (marker as the last word).

Decomposition:
- Package boot_pkg holds:
  - enum boot_state_t {IDLE, HEADER, LOAD, START, RUN, FAULT}
  - enum boot_err_t {ERR_NONE=0, ERR_OVERFLOW=1, ERR_TIMEOUT=2}
  - localparam END_MARKER=32'hFFFFFFFF
- One sub-module, word_assembler: byte index, shift register, a word_valid pulse and a clear input. The FSM and timeout logic stay in the top module.

Test Plan:
- Basic load: header 3; words 0x11223344, 0xFFFFFFFF, 0xAABBCCDD → writes at addr 0,1,2 with those values; pc_init=2; one cpu_start pulse one cycle after the addr-2 write; cpu_reset falls the same cycle.
- Byte order and gaps: send 0x12,0x34,0x56,0x78 with 50-cycle gaps → imem_wdata=0x12345678; no timeout (TIMEOUT_CYCLES reduced to 100 in the bench).
- Overflow: header 1025 with MEM_INST_SIZE=1024 → error=1, FAULT, no imem_we, cpu_reset stays 1; drop boot_req → IDLE.
- Timeout: header 2, one full word, then 2 bytes and silence → error=2 after TIMEOUT_CYCLES; exactly one write seen; error clears on the next boot_req.
- Halt and reload: run, raise cpu_halt → cpu_reset=1 and state IDLE; reload header 1 with word 0xFFFFFFFF → pc_init=1; the previous pc_init value is not retained.
- Mid-load RST, plus N=0 edge: RST after 5 payload bytes → all outputs at reset values and no spurious write. Header 0 → cpu_start one cycle after the header's 4th byte; pc_init=0.
